// File: rtl/encoder_frame_ctrl.sv
// Frame sequencer for the K=3/K=7 convolutional encoder: accepts one frame,
// clears the encoder, shifts data MSB first plus zero tail bits, and streams symbols out.
module encoder_frame_ctrl #(
    parameter int FRAME_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FRAME_LEN-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic                 cl_sel,
    output logic                 enc_cl,
    output logic                 enc_clear,
    output logic                 enc_shift,
    output logic                 enc_bit,
    input  logic                 enc_out1,
    input  logic                 enc_out2,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [1:0]           sym_data,
    output logic                 done
);

    localparam int CNT_W = $clog2(FRAME_LEN + 8);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DATA,
        TAIL,
        DRAIN
    } state_t;

    state_t               state;
    logic [FRAME_LEN-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 slot_free;
    logic                 shifting;
    logic                 handshake;
    logic                 last_data;
    logic                 last_tail;

    // A shift may only happen when the one-symbol output slot is empty or draining now.
    assign slot_free = !sym_valid || sym_ready;
    assign shifting  = ((state == DATA) || (state == TAIL)) && slot_free;
    assign handshake = sym_valid && sym_ready;
    assign last_data = (cnt == CNT_W'(FRAME_LEN - 1));
    assign last_tail = (cnt == (enc_cl ? CNT_W'(5) : CNT_W'(1)));

    assign enc_shift = shifting;
    assign enc_bit   = (state == DATA) && slot_free && shreg[FRAME_LEN-1];
    assign sym_data  = {enc_out1, enc_out2};
    assign done      = (state == DRAIN) && handshake;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            frame_ready <= 1'b1;
            enc_clear   <= 1'b0;
            enc_cl      <= 1'b0;
            sym_valid   <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
        end else begin
            enc_clear <= 1'b0;

            // A new shift refills the slot even if the old symbol leaves this cycle.
            if (shifting) begin
                sym_valid <= 1'b1;
            end else if (sym_ready) begin
                sym_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_valid && frame_ready) begin
                        shreg       <= frame_data;
                        enc_cl      <= cl_sel;
                        frame_ready <= 1'b0;
                        enc_clear   <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= DATA;
                end
                DATA: begin
                    if (shifting) begin
                        shreg <= shreg << 1;
                        if (last_data) begin
                            cnt   <= '0;
                            state <= TAIL;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                TAIL: begin
                    if (shifting) begin
                        if (last_tail) begin
                            cnt   <= '0;
                            state <= DRAIN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        frame_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// Bench for encoder_frame_ctrl: two instances (FRAME_LEN=8 and 1), a stub encoder,
// a frame-level behavioural model compared every cycle, and literal timing checks.
module tb_encoder_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic       rst         [2];
    logic [7:0] frame_data  [2];
    logic       frame_valid [2];
    logic       frame_ready [2];
    logic       cl_sel      [2];
    logic       enc_cl      [2];
    logic       enc_clear   [2];
    logic       enc_shift   [2];
    logic       enc_bit     [2];
    logic       enc_out1    [2];
    logic       enc_out2    [2];
    logic       sym_valid   [2];
    logic       sym_ready   [2];
    logic [1:0] sym_data    [2];
    logic       done        [2];

    encoder_frame_ctrl #(.FRAME_LEN(8)) dut8 (
        .clk(clk), .rst(rst[0]), .frame_data(frame_data[0]), .frame_valid(frame_valid[0]),
        .frame_ready(frame_ready[0]), .cl_sel(cl_sel[0]), .enc_cl(enc_cl[0]),
        .enc_clear(enc_clear[0]), .enc_shift(enc_shift[0]), .enc_bit(enc_bit[0]),
        .enc_out1(enc_out1[0]), .enc_out2(enc_out2[0]), .sym_valid(sym_valid[0]),
        .sym_ready(sym_ready[0]), .sym_data(sym_data[0]), .done(done[0])
    );

    encoder_frame_ctrl #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst[1]), .frame_data(frame_data[1][0:0]), .frame_valid(frame_valid[1]),
        .frame_ready(frame_ready[1]), .cl_sel(cl_sel[1]), .enc_cl(enc_cl[1]),
        .enc_clear(enc_clear[1]), .enc_shift(enc_shift[1]), .enc_bit(enc_bit[1]),
        .enc_out1(enc_out1[1]), .enc_out2(enc_out2[1]), .sym_valid(sym_valid[1]),
        .sym_ready(sym_ready[1]), .sym_data(sym_data[1]), .done(done[1])
    );

    // Stub K=3 encoder (generators 7,5); outputs hold the result of the last shift.
    logic s1 [2];
    logic s2 [2];
    initial begin
        for (int u = 0; u < 2; u++) begin
            s1[u] = 1'b0; s2[u] = 1'b0; enc_out1[u] = 1'b0; enc_out2[u] = 1'b0;
        end
    end
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (enc_clear[u]) begin
                s1[u] <= 1'b0; s2[u] <= 1'b0; enc_out1[u] <= 1'b0; enc_out2[u] <= 1'b0;
            end else if (enc_shift[u]) begin
                enc_out1[u] <= enc_bit[u] ^ s1[u] ^ s2[u];
                enc_out2[u] <= enc_bit[u] ^ s2[u];
                s1[u]       <= enc_bit[u];
                s2[u]       <= s1[u];
            end
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input int u, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (dut%0d): got %0d, expected %0d", name, u, act, exp);
        end
    endtask

    function automatic int frame_len(input int u);
        return (u == 0) ? 8 : 1;
    endfunction

    // Frame-level model: a frame is a list of bits, symbols follow from the bit history.
    bit         armed    [2];
    bit         busy     [2];
    bit         clr_now  [2];
    bit         started  [2];
    bit         m_cl     [2];
    int         total    [2];
    int         n_shift  [2];
    int         n_sym    [2];
    bit         bits     [2][16];
    logic [1:0] syms     [2][16];
    int         acc_cycle [2];
    int         acc_count [2];
    int         done_count [2];

    int          dut_clear_cycle [2];
    int          dut_done_cycle  [2];
    int          dut_done_pulses [2];
    int          dut_shifts      [2];
    int          dut_syms        [2];
    logic [15:0] dut_bit_log     [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            armed[u] = 0; busy[u] = 0; clr_now[u] = 0; started[u] = 0; m_cl[u] = 0;
            total[u] = 0; n_shift[u] = 0; n_sym[u] = 0;
            acc_cycle[u] = 0; acc_count[u] = 0; done_count[u] = 0;
            dut_clear_cycle[u] = 0; dut_done_cycle[u] = 0; dut_done_pulses[u] = 0;
            dut_shifts[u] = 0; dut_syms[u] = 0; dut_bit_log[u] = '0;
        end
    end

    always @(negedge clk) begin : compare
        bit ev, es, eb, hs, ed, was_busy, b0, b1, b2;
        int fl;
        for (int u = 0; u < 2; u++) begin
            ev = started[u] && (n_shift[u] > n_sym[u]);
            es = started[u] && (n_shift[u] < total[u]) && (!ev || sym_ready[u]);
            eb = es ? bits[u][n_shift[u]] : 1'b0;
            hs = ev && sym_ready[u];
            ed = hs && (n_sym[u] + 1 == total[u]);
            if (armed[u]) begin
                checkOutput("frame_ready", u, frame_ready[u], !busy[u]);
                checkOutput("enc_clear", u, enc_clear[u], clr_now[u]);
                checkOutput("enc_cl", u, enc_cl[u], m_cl[u]);
                checkOutput("enc_shift", u, enc_shift[u], es);
                checkOutput("enc_bit", u, enc_bit[u], eb);
                checkOutput("sym_valid", u, sym_valid[u], ev);
                checkOutput("done", u, done[u], ed);
                if (ev) checkOutput("sym_data", u, sym_data[u], syms[u][n_sym[u]]);
                if (enc_shift[u]) begin
                    dut_bit_log[u] = {dut_bit_log[u][14:0], enc_bit[u]};
                    dut_shifts[u]++;
                end
                if (sym_valid[u] && sym_ready[u]) dut_syms[u]++;
                if (enc_clear[u]) dut_clear_cycle[u] = cycle;
                if (done[u]) begin
                    dut_done_cycle[u] = cycle;
                    dut_done_pulses[u]++;
                end
            end
            if (!rst[u]) begin
                armed[u] = 1; busy[u] = 0; clr_now[u] = 0; started[u] = 0; m_cl[u] = 0;
                total[u] = 0; n_shift[u] = 0; n_sym[u] = 0;
            end else if (armed[u]) begin
                was_busy = busy[u];
                if (ed) begin
                    done_count[u]++;
                    started[u] = 0;
                    busy[u] = 0;
                end
                if (hs) n_sym[u]++;
                if (es) n_shift[u]++;
                if (clr_now[u]) begin
                    clr_now[u] = 0;
                    started[u] = 1;
                end
                if (!was_busy && frame_valid[u]) begin
                    fl = frame_len(u);
                    busy[u] = 1; clr_now[u] = 1; m_cl[u] = cl_sel[u];
                    total[u] = fl + (cl_sel[u] ? 6 : 2);
                    n_shift[u] = 0; n_sym[u] = 0;
                    for (int i = 0; i < total[u]; i++)
                        bits[u][i] = (i < fl) ? frame_data[u][fl-1-i] : 1'b0;
                    for (int i = 0; i < total[u]; i++) begin
                        b0 = bits[u][i];
                        b1 = (i >= 1) ? bits[u][i-1] : 1'b0;
                        b2 = (i >= 2) ? bits[u][i-2] : 1'b0;
                        syms[u][i] = {b0 ^ b1 ^ b2, b0 ^ b2};
                    end
                    acc_cycle[u] = cycle;
                    acc_count[u]++;
                    dut_shifts[u] = 0; dut_syms[u] = 0; dut_bit_log[u] = '0;
                end
            end
        end
    end

    task automatic applyStimulus(input int u, input logic [7:0] data, input logic cl, input bit hold);
        int start;
        start = acc_count[u];
        frame_data[u]  = data;
        cl_sel[u]      = cl;
        frame_valid[u] = 1'b1;
        for (int k = 0; k < 30 && acc_count[u] == start; k++) begin
            @(posedge clk); #1;
        end
        if (!hold) frame_valid[u] = 1'b0;
        if (acc_count[u] == start) checkOutput("accept timeout", u, 0, 1);
    endtask

    task automatic waitDone(input int u);
        int start;
        start = done_count[u];
        for (int k = 0; k < 60 && done_count[u] == start; k++) begin
            @(posedge clk); #1;
        end
        if (done_count[u] == start) checkOutput("done timeout", u, 0, 1);
    endtask

    task automatic checkFrame(input string name, input int u, input int lat, input int n,
                              input int log_bits);
        checkOutput({name, " clear latency"}, u, dut_clear_cycle[u] - acc_cycle[u], 1);
        checkOutput({name, " done latency"}, u, dut_done_cycle[u] - acc_cycle[u], lat);
        checkOutput({name, " shifts"}, u, dut_shifts[u], n);
        checkOutput({name, " symbols"}, u, dut_syms[u], n);
        checkOutput({name, " enc_bit sequence"}, u, int'(dut_bit_log[u]), log_bits);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int pulses;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; frame_data[u] = '0; frame_valid[u] = 1'b0;
            cl_sel[u] = 1'b0; sym_ready[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(negedge clk);
        checkOutput("reset frame_ready", 0, frame_ready[0], 1);
        checkOutput("reset sym_valid", 0, sym_valid[0], 0);
        checkOutput("reset enc_cl", 0, enc_cl[0], 0);
        @(posedge clk); #1;

        $display("[TB] T1: K=3 frame 11101000");
        applyStimulus(0, 8'b11101000, 1'b0, 0);
        waitDone(0);
        checkFrame("T1", 0, 12, 10, 16'b1110100000);
        @(negedge clk);
        checkOutput("T1 frame_ready after done", 0, frame_ready[0], 1);
        @(posedge clk); #1;

        $display("[TB] T2: K=7 frame 11101000");
        applyStimulus(0, 8'b11101000, 1'b1, 0);
        waitDone(0);
        checkFrame("T2", 0, 16, 14, 16'b11101000000000);
        checkOutput("T2 enc_cl", 0, enc_cl[0], 1);
        @(posedge clk); #1;

        $display("[TB] T3: backpressure after second symbol");
        applyStimulus(0, 8'b11101000, 1'b0, 0);
        for (int k = 0; k < 30 && n_sym[0] < 2; k++) begin
            @(posedge clk); #1;
        end
        sym_ready[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        sym_ready[0] = 1'b1;
        waitDone(0);
        checkFrame("T3", 0, 15, 10, 16'b1110100000);
        @(posedge clk); #1;

        $display("[TB] T4: frame_valid held while busy");
        applyStimulus(0, 8'b11101000, 1'b0, 1);
        frame_data[0] = 8'h5A;
        cl_sel[0]     = 1'b1;
        waitDone(0);
        checkFrame("T4a", 0, 12, 10, 16'b1110100000);
        begin
            int d1, a1;
            d1 = dut_done_cycle[0];
            a1 = acc_count[0];
            for (int k = 0; k < 10 && acc_count[0] == a1; k++) begin
                @(posedge clk); #1;
            end
            frame_valid[0] = 1'b0;
            checkOutput("T4 second accept after done", 0, acc_cycle[0] - d1, 1);
        end
        waitDone(0);
        checkFrame("T4b", 0, 16, 14, 16'b01011010000000);
        checkOutput("T4 enc_cl second frame", 0, enc_cl[0], 1);
        @(posedge clk); #1;

        $display("[TB] T5: reset during tail");
        pulses = dut_done_pulses[0];
        applyStimulus(0, 8'b11101000, 1'b0, 0);
        for (int k = 0; k < 30 && n_shift[0] < 9; k++) begin
            @(posedge clk); #1;
        end
        rst[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b1;
        @(negedge clk);
        checkOutput("T5 frame_ready", 0, frame_ready[0], 1);
        checkOutput("T5 sym_valid", 0, sym_valid[0], 0);
        checkOutput("T5 enc_shift", 0, enc_shift[0], 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("T5 no done pulse", 0, dut_done_pulses[0], pulses);
        applyStimulus(0, 8'b11101000, 1'b0, 0);
        waitDone(0);
        checkFrame("T5 rerun", 0, 12, 10, 16'b1110100000);
        @(posedge clk); #1;

        $display("[TB] T6: FRAME_LEN=1");
        applyStimulus(1, 8'h01, 1'b0, 0);
        waitDone(1);
        checkFrame("T6", 1, 5, 3, 16'b100);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
